flash_txn_ctrl: RTL and testbench
=================================

Name: flash_txn_ctrl

Overview:
Host-side transaction sequencer for the flash read/write service. It accepts one 16-bit-address / 64-bit-data read or write request at a time and breaks it into packet-engine phases: an OUT-address phase, then an OUT-data phase for writes or an IN-data phase for reads. It owns retry, NAK/corruption handling and the no-response watchdog. It returns a single success/fail response, mirroring the host-level writeData/readData task semantics in RTL.

Parameters:
MAX_RETRY, 8, attempts per phase before the transaction fails (1..15)
TIMEOUT_CYC, 255, cycles after eng_start with no eng_done before the attempt counts as failed (1..255)

Ports:
clk  in  1  system clock
rst_L  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller idle, request accepted when valid&ready
req_write  in  1  1=write, 0=read
req_addr  in  16  flash address
req_wdata  in  64  write data
rsp_valid  out  1  one-cycle response pulse
rsp_success  out  1  transaction completed with ACK on all phases
rsp_rdata  out  64  read data (0 on write or failure)
eng_start  out  1  one-cycle pulse, launch packet phase
eng_kind  out  2  phase_e: OUT_ADDR, OUT_DATA, IN_DATA
eng_payload  out  64  OUT_ADDR: zero-extended addr; OUT_DATA: wdata; IN_DATA: 0
eng_done  in  1  one-cycle pulse, phase finished
eng_status  in  2  status_e: ACK, NAK, CRC_ERR, valid with eng_done
eng_rdata  in  64  received data, valid with eng_done on IN_DATA/ACK

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=1; rsp_valid=0, rsp_success=0, rsp_rdata=0; eng_start=0, eng_kind=OUT_ADDR, eng_payload=0; counters 0.
- FSM states: IDLE, ADDR_ISSUE, ADDR_WAIT, DATA_ISSUE, DATA_WAIT, RESP.
- IDLE: req_ready=1. On valid&ready, latch write/addr/wdata and go to ADDR_ISSUE. req_ready=0 in every other state.
- x_ISSUE: eng_start=1 for exactly one cycle with eng_kind/eng_payload set; load watchdog=TIMEOUT_CYC; go to x_WAIT. eng_kind/eng_payload stay stable until the next ISSUE.
- x_WAIT: watchdog decrements each cycle.
  - eng_done with ACK: ADDR phase goes to DATA_ISSUE (kind OUT_DATA if write, IN_DATA if read). DATA phase goes to RESP with success=1, and on a read latches eng_rdata.
  - eng_done with NAK or CRC_ERR, or watchdog reaching 0 with no eng_done: attempt fails; attempt counter increments.
  - Failed attempt with counter < MAX_RETRY: reissue the same phase (ISSUE in the next cycle).
  - Failed attempt with counter = MAX_RETRY: go to RESP with success=0, rdata=0.
  - eng_done in the same cycle the watchdog expires: eng_done wins.
  - eng_done outside x_WAIT is ignored.
- The attempt counter clears on entry to each new phase, so the budget is per phase, not per transaction.
- RESP: rsp_valid=1 for one cycle with rsp_success/rsp_rdata; next state IDLE. rsp_success/rsp_rdata hold until the next RESP.
- Latency, all-ACK engine answering in d cycles: accept at T, eng_start at T+1, ADDR done at T+1+d, second eng_start at T+2+d, DATA done at T+2+2d, rsp_valid at T+3+2d.
- Reads of unwritten addresses need no special case: whatever the engine returns with ACK is reported, with success=1.
- Reset mid-transaction aborts immediately. No rsp_valid is produced for the aborted request, and the counters clear.

Decomposition:
- Package flash_txn_pkg: phase_e, status_e, state_e enums; ADDR_W=16, DATA_W=64.
- Sub-module flash_txn_watchdog: loadable down-counter with expire pulse. Inputs: load, run. Output: expire.
- Everything else (FSM, latches, attempt counter) lives in flash_txn_ctrl.

Test Plan:
- Write addr 0x00AB, data 0xCAFEBABEDEADBEEF, engine ACKs with d=3 -> eng_start at T+1 (OUT_ADDR, payload 0xAB) and T+5 (OUT_DATA, payload 0xCAFEBABEDEADBEEF); rsp_valid at T+9, success=1, rdata=0.
- Read addr 0x00AB, engine returns 0xCAFEBABEDEADBEEF with ACK -> kinds OUT_ADDR then IN_DATA; rsp_success=1, rsp_rdata=0xCAFEBABEDEADBEEF.
- Read addr 0x00AC, engine returns 0 with ACK -> rsp_success=1, rsp_rdata=0.
- Write where OUT_DATA gets NAK, CRC_ERR, NAK, then ACK -> exactly 4 OUT_DATA eng_start pulses and only 1 OUT_ADDR; success=1.
- OUT_ADDR gets NAK 8 times (MAX_RETRY=8) -> 8 starts, rsp_success=0, rsp_rdata=0, req_ready=1 the next cycle. Separately, engine silent with TIMEOUT_CYC=10 -> reissue every 12 cycles, fail after 8 attempts.
- rst_L low during DATA_WAIT -> outputs reach reset values with no clock edge; no rsp_valid; next request runs normally from ADDR_ISSUE.

Source files
------------

// File: rtl/flash_txn_pkg.sv
// Shared types for the flash transaction sequencer.
// Phase, engine status and FSM state encodings plus bus widths.
package flash_txn_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        OUT_ADDR = 2'd0,
        OUT_DATA = 2'd1,
        IN_DATA  = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        ACK     = 2'd0,
        NAK     = 2'd1,
        CRC_ERR = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_ISSUE,
        ADDR_WAIT,
        DATA_ISSUE,
        DATA_WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/flash_txn_watchdog.sv
// No-response watchdog: loaded on each phase launch, counts down while
// waiting; expire is high for the wait cycle in which the count is zero.
module flash_txn_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_L,
    input  logic load,
    input  logic run,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            count <= '0;
        end else if (load) begin
            count <= 8'(TIMEOUT_CYC);
        end else if (run && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign expire = run && (count == 8'd0);

endmodule

// File: rtl/flash_txn_ctrl.sv
// Host-side flash read/write sequencer: splits a request into address and
// data packet phases with per-phase retry and a no-response watchdog.
module flash_txn_ctrl
    import flash_txn_pkg::*;
#(
    parameter int MAX_RETRY   = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_success,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              eng_start,
    output logic [1:0]        eng_kind,
    output logic [DATA_W-1:0] eng_payload,
    input  logic              eng_done,
    input  logic [1:0]        eng_status,
    input  logic [DATA_W-1:0] eng_rdata
);

    state_e            state;
    state_e            state_nx;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        attempt;
    phase_e            kind_q;
    logic [DATA_W-1:0] payload_q;
    logic              success_q;
    logic [DATA_W-1:0] rdata_q;

    logic in_issue;
    logic in_wait;
    logic expire;
    logic ack;
    logic bad;
    logic last;

    assign in_issue = (state == ADDR_ISSUE) || (state == DATA_ISSUE);
    assign in_wait  = (state == ADDR_WAIT) || (state == DATA_WAIT);

    // A done pulse in the expiry cycle takes precedence over the timeout.
    assign ack  = in_wait && eng_done && (status_e'(eng_status) == ACK);
    assign bad  = in_wait && (eng_done ? (status_e'(eng_status) != ACK) : expire);
    assign last = ({1'b0, attempt} + 5'd1) >= 5'(MAX_RETRY);

    flash_txn_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst_L (rst_L),
        .load  (in_issue),
        .run   (in_wait),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:       if (req_valid) state_nx = ADDR_ISSUE;
            ADDR_ISSUE: state_nx = ADDR_WAIT;
            ADDR_WAIT: begin
                if (ack)      state_nx = DATA_ISSUE;
                else if (bad) state_nx = last ? RESP : ADDR_ISSUE;
            end
            DATA_ISSUE: state_nx = DATA_WAIT;
            DATA_WAIT: begin
                if (ack)      state_nx = RESP;
                else if (bad) state_nx = last ? RESP : DATA_ISSUE;
            end
            RESP:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        eng_start = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE:                   req_ready = 1'b1;
            ADDR_ISSUE, DATA_ISSUE: eng_start = 1'b1;
            RESP:                   rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            attempt   <= '0;
            kind_q    <= OUT_ADDR;
            payload_q <= '0;
            success_q <= 1'b0;
            rdata_q   <= '0;
        end else if (state == IDLE) begin
            if (req_valid) begin
                wr_q      <= req_write;
                wdata_q   <= req_wdata;
                attempt   <= '0;
                kind_q    <= OUT_ADDR;
                payload_q <= DATA_W'(req_addr);
            end
        end else if (ack && state == ADDR_WAIT) begin
            attempt   <= '0;
            kind_q    <= wr_q ? OUT_DATA : IN_DATA;
            payload_q <= wr_q ? wdata_q : '0;
        end else if (ack) begin
            success_q <= 1'b1;
            rdata_q   <= wr_q ? '0 : eng_rdata;
        end else if (bad) begin
            attempt <= attempt + 4'd1;
            if (last) begin
                success_q <= 1'b0;
                rdata_q   <= '0;
            end
        end
    end

    assign eng_kind    = kind_q;
    assign eng_payload = payload_q;
    assign rsp_success = success_q;
    assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_flash_txn_ctrl.sv
// Scoreboard bench for flash_txn_ctrl with a scripted packet-engine responder.
// Expected phase launches and responses come from a transaction-level model.
`timescale 1ns/1ps
module tb_flash_txn_ctrl;

    localparam int MAXR = 8;
    localparam int TMO  = 10;

    localparam logic [1:0] K_ADDR  = 2'd0;
    localparam logic [1:0] K_WDATA = 2'd1;
    localparam logic [1:0] K_RDATA = 2'd2;

    localparam int S_ACK = 0;
    localparam int S_NAK = 1;
    localparam int S_CRC = 2;
    localparam int S_SIL = 3;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_success;
    logic [63:0] rsp_rdata;
    logic        eng_start;
    logic [1:0]  eng_kind;
    logic [63:0] eng_payload;
    logic        eng_done = 1'b0;
    logic [1:0]  eng_status = 2'd0;
    logic [63:0] eng_rdata = '0;

    flash_txn_ctrl #(
        .MAX_RETRY  (MAXR),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_success(rsp_success),
        .rsp_rdata  (rsp_rdata),
        .eng_start  (eng_start),
        .eng_kind   (eng_kind),
        .eng_payload(eng_payload),
        .eng_done   (eng_done),
        .eng_status (eng_status),
        .eng_rdata  (eng_rdata)
    );

    typedef struct {
        int          st;
        logic [63:0] rd;
        int          dly;
    } eresp_t;

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] pl;
    } estart_t;

    typedef struct {
        logic        ok;
        logic [63:0] rd;
    } ersp_t;

    eresp_t  eng_q[$];
    estart_t exp_start[$];
    ersp_t   exp_rsp[$];
    int      start_t[$];
    logic [1:0] start_k[$];
    int      rsp_t[$];
    int      a_scr[$];
    int      d_scr[$];
    int      dly_fix = 0;
    int      cyc = 0;
    int      rsp_cnt = 0;
    int      checks = 0;
    int      errors = 0;
    int      T = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Engine responder: each launch consumes one scripted answer.
    eresp_t cur;
    bit     busy = 0;
    int     wcnt = 0;
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (busy) begin
            wcnt--;
            if (wcnt <= 0) begin
                busy = 0;
                if (cur.st != S_SIL) begin
                    eng_done   = 1'b1;
                    eng_status = 2'(cur.st);
                    eng_rdata  = cur.rd;
                end
            end
        end
        if (rst_L && eng_start) begin
            checks++;
            if (eng_q.size() == 0) begin
                errors++;
                $display("FAIL engine_script unexpected launch kind=%0d", eng_kind);
                cur = '{S_ACK, 64'h0, 1};
            end else begin
                cur = eng_q.pop_front();
            end
            busy = 1;
            wcnt = cur.dly;
        end
    end

    // Monitor: compares launches and responses against the model queues.
    bit      rsp_prev = 0;
    estart_t es;
    ersp_t   er;
    always @(negedge clk) begin
        if (rst_L) begin
            if (rsp_prev) chk("ready_after_rsp", 64'(req_ready), 64'd1);
            rsp_prev = rsp_valid;
            if (eng_start) begin
                start_t.push_back(cyc + 1);
                start_k.push_back(eng_kind);
                chk("ready_low_busy", 64'(req_ready), 64'd0);
                checks++;
                if (exp_start.size() == 0) begin
                    errors++;
                    $display("FAIL start_expected got kind=%0d want none", eng_kind);
                end else begin
                    es = exp_start.pop_front();
                    chk("eng_kind", 64'(eng_kind), 64'(es.kind));
                    chk("eng_payload", eng_payload, es.pl);
                end
            end
            if (rsp_valid) begin
                rsp_t.push_back(cyc + 1);
                rsp_cnt++;
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_expected got success=%0d want none", rsp_success);
                end else begin
                    er = exp_rsp.pop_front();
                    chk("rsp_success", 64'(rsp_success), 64'(er.ok));
                    chk("rsp_rdata", rsp_rdata, er.rd);
                end
            end
        end else begin
            rsp_prev = 0;
        end
    end

    task automatic plan_phase(input bit dph, input logic [1:0] k, input logic [63:0] pl,
                              input logic [63:0] rd, output bit ok);
        int st;
        eresp_t r;
        ok = 0;
        for (int i = 0; i < MAXR; i++) begin
            if (dph) st = (i < d_scr.size()) ? d_scr[i] : S_ACK;
            else     st = (i < a_scr.size()) ? a_scr[i] : S_ACK;
            exp_start.push_back('{k, pl});
            r.st  = st;
            r.rd  = (st == S_ACK) ? rd : {$urandom, $urandom};
            r.dly = (dly_fix > 0) ? dly_fix : int'($urandom_range(1, 11));
            eng_q.push_back(r);
            if (st == S_ACK) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic plan(input bit w, input logic [15:0] a, input logic [63:0] wd,
                        input logic [63:0] rd);
        bit aok;
        bit dok;
        ersp_t x;
        plan_phase(0, K_ADDR, {48'h0, a}, {$urandom, $urandom}, aok);
        dok = 0;
        if (aok) plan_phase(1, w ? K_WDATA : K_RDATA, w ? wd : 64'h0, rd, dok);
        x.ok = aok && dok;
        x.rd = (x.ok && !w) ? rd : 64'h0;
        exp_rsp.push_back(x);
    endtask

    task automatic issue(input bit w, input logic [15:0] a, input logic [63:0] wd);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        T = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrived", 64'(rsp_cnt >= target), 64'd1);
        @(negedge clk);
        chk("launches_consumed", 64'(exp_start.size()), 64'd0);
        chk("script_consumed", 64'(eng_q.size()), 64'd0);
    endtask

    task automatic run(input bit w, input logic [15:0] a, input logic [63:0] wd,
                       input logic [63:0] rd);
        int tgt;
        start_t.delete();
        start_k.delete();
        rsp_t.delete();
        plan(w, a, wd, rd);
        tgt = rsp_cnt + 1;
        issue(w, a, wd);
        wait_rsp(tgt);
    endtask

    function automatic int count_kind(input logic [1:0] k);
        int c = 0;
        foreach (start_k[i]) if (start_k[i] == k) c++;
        return c;
    endfunction

    function automatic int nfails();
        if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 2));
        return int'($urandom_range(0, MAXR));
    endfunction

    function automatic int rand_fail();
        int r = int'($urandom_range(0, 5));
        if (r < 2) return S_NAK;
        if (r < 4) return S_CRC;
        if (r == 4) return S_SIL;
        return S_NAK;
    endfunction

    int base;
    int n;
    int nf;
    logic [63:0] wd_r;
    logic [63:0] rd_r;

    initial begin
        #3;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_success", 64'(rsp_success), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        chk("rst_eng_kind", 64'(eng_kind), 64'(K_ADDR));
        chk("rst_eng_payload", eng_payload, 64'd0);
        repeat (3) @(negedge clk);
        rst_L = 1'b1;

        // Write with fixed engine latency 3: launches at T+1, T+5, response at T+9.
        dly_fix = 3;
        run(1, 16'h00AB, 64'hCAFEBABEDEADBEEF, 64'h0);
        chk("lat_starts", 64'(start_t.size()), 64'd2);
        chk("lat_start0", 64'(start_t[0]), 64'(T + 1));
        chk("lat_start1", 64'(start_t[1]), 64'(T + 5));
        chk("lat_rsp", 64'(rsp_t[0]), 64'(T + 9));
        dly_fix = 0;

        run(0, 16'h00AB, 64'h0, 64'hCAFEBABEDEADBEEF);
        chk("rd_kind_data", 64'(count_kind(K_RDATA)), 64'd1);
        run(0, 16'h00AC, 64'h0, 64'h0);

        // Data phase retried: NAK, CRC_ERR, NAK, then ACK.
        d_scr = '{S_NAK, S_CRC, S_NAK};
        run(1, 16'h1234, 64'h0123456789ABCDEF, 64'h0);
        chk("retry_addr_starts", 64'(count_kind(K_ADDR)), 64'd1);
        chk("retry_data_starts", 64'(count_kind(K_WDATA)), 64'd4);
        d_scr.delete();

        // Address phase exhausts its budget with NAKs.
        repeat (MAXR) a_scr.push_back(S_NAK);
        run(0, 16'h0042, 64'h0, 64'hFFFF0000FFFF0000);
        chk("nak_fail_starts", 64'(start_t.size()), 64'(MAXR));

        // Silent engine: watchdog reissues every TMO+2 cycles.
        a_scr.delete();
        repeat (MAXR) a_scr.push_back(S_SIL);
        run(1, 16'h0077, 64'h5555AAAA5555AAAA, 64'h0);
        chk("sil_starts", 64'(start_t.size()), 64'(MAXR));
        for (int i = 1; i < start_t.size(); i++)
            chk("sil_period", 64'(start_t[i] - start_t[i-1]), 64'(TMO + 2));
        a_scr.delete();

        // Done arrives in the very cycle the watchdog expires.
        dly_fix = TMO + 1;
        run(0, 16'h0099, 64'h0, 64'h1122334455667788);
        chk("tie_starts", 64'(start_t.size()), 64'd2);

        // Reset during the data wait aborts with no response.
        dly_fix = 8;
        start_t.delete();
        start_k.delete();
        plan(1, 16'h0101, 64'hA5A5A5A5A5A5A5A5, 64'h0);
        base = rsp_cnt;
        issue(1, 16'h0101, 64'hA5A5A5A5A5A5A5A5);
        n = 0;
        while (start_t.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_data", 64'(start_t.size()), 64'd2);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_L = 1'b0;
        #1;
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_eng_start", 64'(eng_start), 64'd0);
        chk("abort_eng_kind", 64'(eng_kind), 64'(K_ADDR));
        chk("abort_eng_payload", eng_payload, 64'd0);
        chk("abort_rsp_success", 64'(rsp_success), 64'd0);
        chk("abort_rsp_rdata", rsp_rdata, 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        eng_q.delete();
        exp_start.delete();
        exp_rsp.delete();
        busy = 0;
        repeat (3) @(negedge clk);
        rst_L = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_rsp", 64'(rsp_cnt), 64'(base));
        dly_fix = 0;
        run(0, 16'h0101, 64'h0, 64'h0F0F0F0F0F0F0F0F);
        chk("post_abort_start", 64'(start_t[0]), 64'(T + 1));

        // Randomized traffic with random failure scripts.
        for (int t = 0; t < 40; t++) begin
            a_scr.delete();
            d_scr.delete();
            nf = nfails();
            for (int i = 0; i < nf; i++) a_scr.push_back(rand_fail());
            nf = nfails();
            for (int i = 0; i < nf; i++) d_scr.push_back(rand_fail());
            wd_r = {$urandom, $urandom};
            rd_r = {$urandom, $urandom};
            run(1'($urandom), 16'($urandom), wd_r, rd_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
